// File: rtl/lsu_data_mem_pkg.sv
// Shared definitions for the load/store data memory.
// Contents:
//   funct3_t       - raw 3-bit funct3 field of a load or store
//   access_size_t  - decoded access size (byte, half, word, double)
//   F3_*           - funct3 encodings for loads and stores
//   f3_size        - funct3 -> access size
//   f3_is_unsigned - funct3 -> zero-extend on load
//   f3_is_legal    - funct3 legality for a given direction and data width
//   size_bytes     - access size -> number of byte lanes touched
package lsu_data_mem_pkg;

  typedef logic [2:0] funct3_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } access_size_t;

  localparam funct3_t F3_LB  = 3'b000;
  localparam funct3_t F3_LH  = 3'b001;
  localparam funct3_t F3_LW  = 3'b010;
  localparam funct3_t F3_LD  = 3'b011;
  localparam funct3_t F3_LBU = 3'b100;
  localparam funct3_t F3_LHU = 3'b101;
  localparam funct3_t F3_LWU = 3'b110;
  localparam funct3_t F3_SB  = 3'b000;
  localparam funct3_t F3_SH  = 3'b001;
  localparam funct3_t F3_SW  = 3'b010;
  localparam funct3_t F3_SD  = 3'b011;

  function automatic access_size_t f3_size(input funct3_t f3);
    return access_size_t'(f3[1:0]);
  endfunction

  function automatic logic f3_is_unsigned(input funct3_t f3);
    return f3[2];
  endfunction

  // Doubleword accesses exist only on a 64-bit datapath; stores have no
  // unsigned variants and load 111 is unassigned.
  function automatic logic f3_is_legal(input funct3_t f3, input logic is_store, input int width);
    logic d_ok;
    d_ok = (f3[1:0] != 2'b11) || (width == 64);
    if (is_store) return !f3[2] && d_ok;
    return (f3 != 3'b111) && d_ok;
  endfunction

  function automatic int size_bytes(input access_size_t s);
    return 1 << int'(s);
  endfunction

endpackage

// File: rtl/lsu_data_mem_if.sv
// Request/response/flash bus between the load/store unit and the data memory.
// Signals:
//   req_valid/req_ready  request handshake (accept = valid & ready)
//   req_wren             0 = load, 1 = store
//   req_addr             byte address
//   req_funct3           access size and sign
//   req_wr_data          store data, LSB-justified
//   resp_valid           one-cycle pulse, one cycle after each accept
//   resp_rd_data         extended load data (0 for stores/errors)
//   resp_err             misaligned/illegal access flag
//   flash_en/addr/data   full-word flash write, overrides the request port
// Modports: master (LSU side / testbench), slave (memory side).
interface lsu_data_mem_if
  import lsu_data_mem_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int FLASH_AW = 11
);

  logic                req_valid;
  logic                req_ready;
  logic                req_wren;
  logic [WIDTH-1:0]    req_addr;
  funct3_t             req_funct3;
  logic [WIDTH-1:0]    req_wr_data;
  logic                resp_valid;
  logic [WIDTH-1:0]    resp_rd_data;
  logic                resp_err;
  logic                flash_en;
  logic [FLASH_AW-1:0] flash_addr;
  logic [WIDTH-1:0]    flash_data;

  modport master (
    output req_valid, req_wren, req_addr, req_funct3, req_wr_data,
    output flash_en, flash_addr, flash_data,
    input  req_ready, resp_valid, resp_rd_data, resp_err
  );

  modport slave (
    input  req_valid, req_wren, req_addr, req_funct3, req_wr_data,
    input  flash_en, flash_addr, flash_data,
    output req_ready, resp_valid, resp_rd_data, resp_err
  );

endinterface

// File: rtl/lsu_data_mem_be_ram.sv
// Single-port RAM with per-byte write enables and a synchronous read.
// Ports:
//   clk    clock
//   addr   word address
//   be     byte-lane write enables (all zero = read only)
//   wdata  write data, one byte per lane
//   q      registered read data of addr (old contents on a write cycle)
// Contents are not reset.
module lsu_be_ram #(
  parameter int WIDTH       = 32,
  parameter int DEPTH_WORDS = 2048
) (
  input  logic                           clk,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [WIDTH/8-1:0]             be,
  input  logic [WIDTH-1:0]               wdata,
  output logic [WIDTH-1:0]               q
);

  localparam int LANES = WIDTH / 8;

  logic [WIDTH-1:0] r_mem [DEPTH_WORDS];

  // Write the enabled lanes and read the addressed word every cycle; the
  // caller decides when q is meaningful.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (be[i]) r_mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
    q <= r_mem[addr];
  end

endmodule

// File: rtl/lsu_data_mem.sv
// Byte-addressable data memory for the load/store path.
// Ports:
//   clk  clock, rising edge
//   rst  asynchronous active-high reset
//   bus  lsu_data_mem_if.slave: request handshake, 1-cycle registered
//        response, flash write port (flash has priority over requests)
// Configuration macro: LSU_MISALIGN_TRAP_EN
//   defined   - misaligned accesses write nothing, return 0 and raise resp_err
//   undefined - misaligned offsets are aligned down, resp_err is always 0
module lsu_data_mem
  import lsu_data_mem_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH_WORDS = 2048,
  parameter int FLASH_AW    = 11
) (
  input  logic          clk,
  input  logic          rst,
  lsu_data_mem_if.slave bus
);

  localparam int LANES = WIDTH / 8;
  localparam int OFF_W = $clog2(LANES);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic               w_accept;
  logic               w_legal;
  logic               w_misaligned;
  logic               w_err;
  logic               w_trap;
  logic               w_store_ok;
  logic               w_load_ok;
  access_size_t       w_size;
  int                 w_bytes;
  logic [OFF_W-1:0]   w_off_raw;
  logic [OFF_W-1:0]   w_off;
  logic [OFF_W-1:0]   w_size_mask;
  logic [OFF_W-1:0]   w_src;
  logic [IDX_W-1:0]   w_idx;
  logic [IDX_W-1:0]   w_ram_addr;
  logic [LANES-1:0]   w_req_be;
  logic [LANES-1:0]   w_ram_be;
  logic [WIDTH-1:0]   w_req_wdata;
  logic [WIDTH-1:0]   w_ram_wdata;
  logic [WIDTH-1:0]   w_ram_q;
  logic [WIDTH-1:0]   w_lane;
  logic [WIDTH-1:0]   w_mask;
  logic [WIDTH-1:0]   w_ext;
  logic               w_sign;

  logic               r_resp_valid;
  logic               r_load_ok;
  logic               r_err;
  logic               r_unsigned;
  access_size_t       r_size;
  logic [OFF_W-1:0]   r_off;

  // Flash owns the single RAM port, so requests stall while it is active.
  assign bus.req_ready = !bus.flash_en;
  assign w_accept      = bus.req_valid && !bus.flash_en;

  assign w_size      = f3_size(bus.req_funct3);
  assign w_bytes     = size_bytes(w_size);
  assign w_legal     = f3_is_legal(bus.req_funct3, bus.req_wren, WIDTH);
  assign w_idx       = bus.req_addr[OFF_W +: IDX_W];
  assign w_off_raw   = bus.req_addr[OFF_W-1:0];
  assign w_size_mask = OFF_W'(w_bytes - 1);

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misaligned = |(w_off_raw & w_size_mask);
  assign w_off        = w_off_raw;
  assign w_err        = !w_legal || w_misaligned;
  assign w_trap       = w_err;
`else
  assign w_misaligned = 1'b0;
  assign w_off        = w_off_raw & ~w_size_mask;
  assign w_err        = !w_legal;
  assign w_trap       = 1'b0;
`endif

  assign w_store_ok = w_accept && bus.req_wren && !w_err && !w_misaligned;
  assign w_load_ok  = !bus.req_wren && !w_err;

  // Store steering: the store data is replicated across every lane in
  // access-sized chunks, and only the lanes covered by the access starting
  // at the (possibly aligned-down) offset get a write enable.
  always_comb begin
    w_req_be    = '0;
    w_req_wdata = '0;
    w_src       = '0;
    for (int i = 0; i < LANES; i++) begin
      w_src = OFF_W'(i) & w_size_mask;
      w_req_wdata[i*8 +: 8] = bus.req_wr_data[{w_src, 3'b000} +: 8];
      if ((i >= int'(w_off)) && (i < int'(w_off) + w_bytes)) w_req_be[i] = 1'b1;
    end
  end

  // RAM port arbitration: flash writes a whole word; otherwise the request
  // address is presented so an accepted load reads at the accept edge.
  always_comb begin
    w_ram_addr  = w_idx;
    w_ram_be    = '0;
    w_ram_wdata = w_req_wdata;
    if (bus.flash_en) begin
      w_ram_addr  = IDX_W'(bus.flash_addr);
      w_ram_be    = '1;
      w_ram_wdata = bus.flash_data;
    end else if (w_store_ok) begin
      w_ram_be = w_req_be;
    end
  end

  lsu_be_ram #(
    .WIDTH       (WIDTH),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_ram (
    .clk   (clk),
    .addr  (w_ram_addr),
    .be    (w_ram_be),
    .wdata (w_ram_wdata),
    .q     (w_ram_q)
  );

  // Response bookkeeping: everything needed to shape the RAM output in the
  // cycle after accept. Reset drops any response still in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_resp_valid <= 1'b0;
      r_load_ok    <= 1'b0;
      r_err        <= 1'b0;
      r_unsigned   <= 1'b0;
      r_size       <= SZ_B;
      r_off        <= '0;
    end else begin
      r_resp_valid <= w_accept;
      if (w_accept) begin
        r_load_ok  <= w_load_ok;
        r_err      <= w_trap;
        r_unsigned <= f3_is_unsigned(bus.req_funct3);
        r_size     <= w_size;
        r_off      <= w_off;
      end
    end
  end

  // Load shaping: shift the addressed lanes down, keep the access-sized
  // field and fill the rest with the sign bit or zeros.
  always_comb begin
    w_lane = w_ram_q >> {r_off, 3'b000};
    w_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i < size_bytes(r_size)) w_mask[i*8 +: 8] = 8'hFF;
    end
    w_sign = 1'b0;
    case (r_size)
      SZ_B:    w_sign = w_lane[7];
      SZ_H:    w_sign = w_lane[15];
      SZ_W:    w_sign = w_lane[31];
      default: w_sign = w_lane[WIDTH-1];
    endcase
    w_ext = (w_lane & w_mask) | ((!r_unsigned && w_sign) ? ~w_mask : '0);
  end

  assign bus.resp_valid   = r_resp_valid;
  assign bus.resp_rd_data = (r_resp_valid && r_load_ok) ? w_ext : '0;
  assign bus.resp_err     = r_resp_valid && r_err;

endmodule

// File: tb/tb_lsu_data_mem.sv
// Testbench for lsu_data_mem (32-bit build). Directed scenarios followed by
// randomized traffic checked against a byte-array reference model.
// Honours LSU_MISALIGN_TRAP_EN for the expected misaligned/illegal results.
module tb_lsu_data_mem;
  import lsu_data_mem_pkg::*;

  localparam int WIDTH       = 32;
  localparam int DEPTH_WORDS = 2048;
  localparam int FLASH_AW    = 11;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lsu_data_mem_if #(.WIDTH(WIDTH), .FLASH_AW(FLASH_AW)) bus ();

  lsu_data_mem #(
    .WIDTH       (WIDTH),
    .DEPTH_WORDS (DEPTH_WORDS),
    .FLASH_AW    (FLASH_AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference memory, one entry per byte address.
  logic [7:0] modelMem [DEPTH_WORDS*4];

  // Response expected right now (curr) and after the next cycle (pend).
  bit          currValid, pendValid;
  logic [31:0] currData, pendData;
  bit          currErr, pendErr;

  // Behavioural model of one accepted request, straight from the access rules.
  function automatic void modelAccess(input bit wren, input logic [31:0] addr, input logic [2:0] f3,
                                      input logic [31:0] wd, output logic [31:0] rd, output bit err);
    int bytes, off, base;
    bit legal, mis;
    logic [31:0] v, mask;
    bytes = 1 << f3[1:0];
    legal = wren ? (f3[2] == 1'b0 && f3[1:0] != 2'b11) : (f3[1:0] != 2'b11);
    off   = int'(addr % 4);
    base  = int'((addr / 4) % DEPTH_WORDS) * 4;
    mis   = (off % bytes) != 0;
    rd    = 32'h0;
    err   = 1'b0;
    if (TRAP && (!legal || mis)) begin
      err = 1'b1;
      return;
    end
    if (!legal) return;
    off = off - (off % bytes);
    if (wren) begin
      for (int k = 0; k < bytes; k++) modelMem[base + off + k] = wd[8*k +: 8];
      return;
    end
    v = 32'h0;
    for (int k = 0; k < bytes; k++) v = v | (32'(modelMem[base + off + k]) << (8*k));
    if (bytes < 4 && f3[2] == 1'b0 && v[8*bytes-1]) begin
      mask = (32'd1 << (8*bytes)) - 32'd1;
      v = v | ~mask;
    end
    rd = v;
  endfunction

  function automatic void modelFlash(input logic [10:0] fa, input logic [31:0] fd);
    for (int k = 0; k < 4; k++) modelMem[int'(fa)*4 + k] = fd[8*k +: 8];
  endfunction

  // Drive one cycle of inputs at the falling edge and advance the model.
  // On return, the DUT outputs show the response for the previous cycle.
  task automatic applyStimulus(input bit v, input bit wren, input logic [31:0] addr, input logic [2:0] f3,
                               input logic [31:0] wd, input bit fen, input logic [10:0] fa, input logic [31:0] fd);
    logic [31:0] rd;
    bit err;
    @(negedge clk);
    bus.req_valid   = v;
    bus.req_wren    = wren;
    bus.req_addr    = addr;
    bus.req_funct3  = f3;
    bus.req_wr_data = wd;
    bus.flash_en    = fen;
    bus.flash_addr  = fa;
    bus.flash_data  = fd;
    currValid = pendValid;
    currData  = pendData;
    currErr   = pendErr;
    pendValid = 1'b0;
    pendData  = 32'h0;
    pendErr   = 1'b0;
    if (fen) begin
      modelFlash(fa, fd);
    end else if (v) begin
      modelAccess(wren, addr, f3, wd, rd, err);
      pendValid = 1'b1;
      pendData  = rd;
      pendErr   = err;
    end
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 32'h0, 3'b000, 32'h0, 1'b0, 11'd0, 32'h0);
  endtask

  task automatic req(input bit wren, input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] wd);
    applyStimulus(1'b1, wren, addr, f3, wd, 1'b0, 11'd0, 32'h0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b, expected 0", bus.resp_valid); end
    checks++; if (bus.resp_rd_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_data: got %h, expected 0", bus.resp_rd_data); end
    checks++; if (bus.resp_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b, expected 0", bus.resp_err); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b, expected 1", bus.req_ready); end
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_valid: got %b, expected 0", bus.resp_valid); end
  endtask

  task automatic init_memory();
    for (int w = 0; w < 16; w++) applyStimulus(1'b0, 1'b0, 32'h0, 3'b000, 32'h0, 1'b1, 11'(w), $urandom);
    idle();
  endtask

  task automatic test_reset_mid_load();
    req(1'b0, 32'h10, F3_LW, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    #1;
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL midload_valid: got %b, expected 0", bus.resp_valid); end
    checks++; if (bus.resp_rd_data !== 32'h0) begin errors++; $display("[TB] FAIL midload_data: got %h, expected 0", bus.resp_rd_data); end
    checks++; if (bus.resp_err !== 1'b0) begin errors++; $display("[TB] FAIL midload_err: got %b, expected 0", bus.resp_err); end
    @(negedge clk);
    rst = 1'b0;
    pendValid = 1'b0;
    idle();
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL midload_dropped: got %b, expected 0", bus.resp_valid); end
  endtask

  task automatic test_word();
    req(1'b1, 32'h10, F3_SW, 32'hDEADBEEF);
    req(1'b0, 32'h10, F3_LW, 32'h0);
    checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("[TB] FAIL sw_resp_valid: got %b, expected 1", bus.resp_valid); end
    checks++; if (bus.resp_rd_data !== 32'h0) begin errors++; $display("[TB] FAIL sw_resp_data: got %h, expected 0", bus.resp_rd_data); end
    idle();
    checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("[TB] FAIL lw_resp_valid: got %b, expected 1", bus.resp_valid); end
    checks++; if (bus.resp_rd_data !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL lw_data: got %h, expected deadbeef", bus.resp_rd_data); end
    idle();
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL lw_single_pulse: got %b, expected 0", bus.resp_valid); end
  endtask

  task automatic test_byte();
    req(1'b1, 32'h13, F3_SB, 32'h12345680);
    req(1'b0, 32'h13, F3_LB, 32'h0);
    req(1'b0, 32'h13, F3_LBU, 32'h0);
    checks++; if (bus.resp_rd_data !== 32'hFFFFFF80) begin errors++; $display("[TB] FAIL lb_sext: got %h, expected ffffff80", bus.resp_rd_data); end
    req(1'b0, 32'h10, F3_LW, 32'h0);
    checks++; if (bus.resp_rd_data !== 32'h00000080) begin errors++; $display("[TB] FAIL lbu_zext: got %h, expected 00000080", bus.resp_rd_data); end
    idle();
    checks++; if (bus.resp_rd_data !== 32'h80ADBEEF) begin errors++; $display("[TB] FAIL sb_lanes: got %h, expected 80adbeef", bus.resp_rd_data); end
  endtask

  task automatic test_half();
    req(1'b1, 32'h12, F3_SH, 32'hABCD1234);
    req(1'b0, 32'h12, F3_LHU, 32'h0);
    req(1'b0, 32'h10, F3_LHU, 32'h0);
    checks++; if (bus.resp_rd_data !== 32'h00001234) begin errors++; $display("[TB] FAIL lhu_data: got %h, expected 00001234", bus.resp_rd_data); end
    req(1'b0, 32'h10, F3_LH, 32'h0);
    checks++; if (bus.resp_rd_data !== 32'h0000BEEF) begin errors++; $display("[TB] FAIL sh_low_half_kept: got %h, expected 0000beef", bus.resp_rd_data); end
    idle();
    checks++; if (bus.resp_rd_data !== 32'hFFFFBEEF) begin errors++; $display("[TB] FAIL lh_sext: got %h, expected ffffbeef", bus.resp_rd_data); end
  endtask

  task automatic test_flash();
    applyStimulus(1'b1, 1'b1, 32'h18, F3_SW, 32'hCAFEF00D, 1'b1, 11'd5, 32'hA5A5A5A5);
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("[TB] FAIL flash_ready: got %b, expected 0", bus.req_ready); end
    req(1'b0, 32'h14, F3_LW, 32'h0);
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL flash_no_accept: got %b, expected 0", bus.resp_valid); end
    req(1'b0, 32'h18, F3_LW, 32'h0);
    checks++; if (bus.resp_rd_data !== 32'hA5A5A5A5) begin errors++; $display("[TB] FAIL flash_word5: got %h, expected a5a5a5a5", bus.resp_rd_data); end
    idle();
    checks++; if (bus.resp_rd_data !== currData) begin errors++; $display("[TB] FAIL flash_blocked_store: got %h, expected %h", bus.resp_rd_data, currData); end
    req(1'b0, 32'h14, F3_LW, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h14, F3_LW, 32'h0, 1'b1, 11'd7, 32'h0F0F0F0F);
    checks++; if (bus.resp_valid !== 1'b1 || bus.resp_rd_data !== 32'hA5A5A5A5) begin
      errors++; $display("[TB] FAIL resp_during_flash: got %b/%h, expected 1/a5a5a5a5", bus.resp_valid, bus.resp_rd_data); end
    idle();
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL flash_cycle_no_resp: got %b, expected 0", bus.resp_valid); end
  endtask

  task automatic test_misalign();
    req(1'b0, 32'h11, F3_LW, 32'h0);
    req(1'b1, 32'h13, F3_SH, 32'h00005555);
    checks++; if (bus.resp_err !== TRAP) begin errors++; $display("[TB] FAIL mis_lw_err: got %b, expected %b", bus.resp_err, TRAP); end
    checks++; if (bus.resp_rd_data !== (TRAP ? 32'h0 : 32'h1234BEEF)) begin
      errors++; $display("[TB] FAIL mis_lw_data: got %h, expected %h", bus.resp_rd_data, TRAP ? 32'h0 : 32'h1234BEEF); end
    req(1'b0, 32'h10, F3_LW, 32'h0);
    checks++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== TRAP) begin
      errors++; $display("[TB] FAIL mis_sh_resp: got %b/%b, expected 1/%b", bus.resp_valid, bus.resp_err, TRAP); end
    idle();
    checks++; if (bus.resp_rd_data !== (TRAP ? 32'h1234BEEF : 32'h5555BEEF)) begin
      errors++; $display("[TB] FAIL mis_sh_mem: got %h, expected %h", bus.resp_rd_data, TRAP ? 32'h1234BEEF : 32'h5555BEEF); end
  endtask

  task automatic test_illegal();
    logic [31:0] word10;
    word10 = TRAP ? 32'h1234BEEF : 32'h5555BEEF;
    req(1'b0, 32'h10, 3'b111, 32'h0);
    req(1'b1, 32'h10, 3'b100, 32'hFFFFFFFF);
    checks++; if (bus.resp_valid !== 1'b1 || bus.resp_rd_data !== 32'h0 || bus.resp_err !== TRAP) begin
      errors++; $display("[TB] FAIL ill_load: got %b/%h/%b, expected 1/0/%b", bus.resp_valid, bus.resp_rd_data, bus.resp_err, TRAP); end
    req(1'b1, 32'h10, F3_SD, 32'hFFFFFFFF);
    checks++; if (bus.resp_err !== TRAP) begin errors++; $display("[TB] FAIL ill_store1xx_err: got %b, expected %b", bus.resp_err, TRAP); end
    req(1'b0, 32'h10, F3_LD, 32'h0);
    checks++; if (bus.resp_err !== TRAP) begin errors++; $display("[TB] FAIL ill_sd_err: got %b, expected %b", bus.resp_err, TRAP); end
    req(1'b0, 32'h10, F3_LW, 32'h0);
    checks++; if (bus.resp_rd_data !== 32'h0) begin errors++; $display("[TB] FAIL ill_ld_data: got %h, expected 0", bus.resp_rd_data); end
    idle();
    checks++; if (bus.resp_rd_data !== word10) begin errors++; $display("[TB] FAIL ill_no_write: got %h, expected %h", bus.resp_rd_data, word10); end
  endtask

  task automatic test_random();
    bit v, wren, fen;
    logic [31:0] a;
    for (int n = 0; n < 400; n++) begin
      fen  = ($urandom % 10) == 0;
      v    = ($urandom % 10) < 7;
      wren = $urandom % 2;
      a    = $urandom;
      a[12:6] = 7'd0;
      applyStimulus(v, wren, a, 3'($urandom), $urandom, fen, 11'($urandom % 16), $urandom);
      checks++; if (bus.req_ready !== !fen) begin errors++; $display("[TB] FAIL rnd_ready[%0d]: got %b, expected %b", n, bus.req_ready, !fen); end
      checks++; if (bus.resp_valid !== currValid) begin errors++; $display("[TB] FAIL rnd_valid[%0d]: got %b, expected %b", n, bus.resp_valid, currValid); end
      if (currValid) begin
        checks++; if (bus.resp_rd_data !== currData || bus.resp_err !== currErr) begin
          errors++; $display("[TB] FAIL rnd_resp[%0d]: got %h/%b, expected %h/%b", n, bus.resp_rd_data, bus.resp_err, currData, currErr); end
      end
    end
    idle();
    checks++; if (bus.resp_valid !== currValid || (currValid && bus.resp_rd_data !== currData)) begin
      errors++; $display("[TB] FAIL rnd_tail: got %b/%h, expected %b/%h", bus.resp_valid, bus.resp_rd_data, currValid, currData); end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bus.req_valid   = 1'b0;
    bus.req_wren    = 1'b0;
    bus.req_addr    = '0;
    bus.req_funct3  = 3'b000;
    bus.req_wr_data = '0;
    bus.flash_en    = 1'b0;
    bus.flash_addr  = '0;
    bus.flash_data  = '0;
    pendValid = 1'b0; pendData = 32'h0; pendErr = 1'b0;
    currValid = 1'b0; currData = 32'h0; currErr = 1'b0;
    #1;
    test_reset();
    init_memory();
    test_reset_mid_load();
    test_word();
    test_byte();
    test_half();
    test_flash();
    test_misalign();
    test_illegal();
    test_random();
    repeat (2) idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
